// File: rtl/rr_arbiter_pkg.sv
// Shared types for the round-robin / fixed-priority arbiter.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_priority_encoder.sv
// Combinational priority encoder: picks one set bit of `bits`, lowest index wins when
// LSB_PRIORITY is "HIGH", highest index wins otherwise.
module priority_encoder #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned INDEX_W      = 2,
  parameter string       LSB_PRIORITY = "LOW"
) (
  input  logic [WIDTH-1:0]   bits,
  output logic               valid_c,
  output logic [INDEX_W-1:0] index_c,
  output logic [WIDTH-1:0]   onehot_c
);

  // Loop order makes the last matching bit the winner.
  always_comb begin
    index_c = '0;
    if (LSB_PRIORITY == "HIGH") begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (bits[i]) index_c = INDEX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (bits[i]) index_c = INDEX_W'(i);
      end
    end
  end

  assign valid_c  = |bits;
  assign onehot_c = valid_c ? (WIDTH'(1) << index_c) : '0;

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way arbiter with optional round-robin rotation and grant holding
// until request drop or explicit acknowledge.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned PORTS                 = 4,
  parameter int unsigned ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int unsigned ARB_BLOCK             = 0,
  parameter int unsigned ARB_BLOCK_ACK         = 1,
  parameter int unsigned ARB_LSB_HIGH_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    request,
  input  logic [PORTS-1:0]    acknowledge,
  output logic [PORTS-1:0]    grant,
  output logic                grant_valid,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] grant_encoded
);

  localparam int unsigned CL_PORTS = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam string       LSB_PRIO = (ARB_LSB_HIGH_PRIORITY != 0) ? "HIGH" : "LOW";

  arb_state_t           state, state_next;
  logic [PORTS-1:0]     grant_next;
  logic [CL_PORTS-1:0]  encoded_next;
  logic [PORTS-1:0]     mask, mask_next;

  logic                 req_valid_c, msk_valid_c;
  logic [CL_PORTS-1:0]  req_index_c, msk_index_c, win_index_c;
  logic [PORTS-1:0]     req_onehot_c, msk_onehot_c, win_onehot_c;
  logic                 rel_ack_c, rel_req_c, release_c, rearb_c;

  priority_encoder #(
    .WIDTH        (PORTS),
    .INDEX_W      (CL_PORTS),
    .LSB_PRIORITY (LSB_PRIO)
  ) u_enc_req (
    .bits     (request),
    .valid_c  (req_valid_c),
    .index_c  (req_index_c),
    .onehot_c (req_onehot_c)
  );

  // Masked encoder only exists for round-robin; fixed priority sees it as always empty.
  if (ARB_TYPE_ROUND_ROBIN != 0) begin : g_rr
    priority_encoder #(
      .WIDTH        (PORTS),
      .INDEX_W      (CL_PORTS),
      .LSB_PRIORITY (LSB_PRIO)
    ) u_enc_msk (
      .bits     (request & mask),
      .valid_c  (msk_valid_c),
      .index_c  (msk_index_c),
      .onehot_c (msk_onehot_c)
    );
  end else begin : g_fixed
    assign msk_valid_c  = 1'b0;
    assign msk_index_c  = '0;
    assign msk_onehot_c = '0;
  end

  assign win_index_c  = msk_valid_c ? msk_index_c  : req_index_c;
  assign win_onehot_c = msk_valid_c ? msk_onehot_c : req_onehot_c;

  // Release of the currently granted port under the selected blocking mode.
  assign rel_ack_c = |(acknowledge & grant);
  assign rel_req_c = ~|(request & grant);
  assign release_c = (ARB_BLOCK == 0)     ? 1'b1 :
                     (ARB_BLOCK_ACK != 0) ? rel_ack_c : rel_req_c;

  always_comb begin
    state_next   = state;
    grant_next   = grant;
    encoded_next = grant_encoded;
    mask_next    = mask;
    rearb_c      = 1'b0;
    case (state)
      IDLE:    rearb_c = 1'b1;
      GRANTED: rearb_c = release_c;
    endcase
    if (rearb_c) begin
      if (req_valid_c) begin
        state_next   = GRANTED;
        grant_next   = win_onehot_c;
        encoded_next = win_index_c;
        // Rotation: only ports past the new winner stay eligible in the masked pass.
        for (int j = 0; j < int'(PORTS); j++) begin
          mask_next[j] = (ARB_LSB_HIGH_PRIORITY != 0) ? (j > int'(win_index_c))
                                                      : (j < int'(win_index_c));
        end
      end else begin
        state_next   = IDLE;
        grant_next   = '0;
        encoded_next = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '1;
    end else begin
      state         <= state_next;
      grant         <= grant_next;
      grant_valid   <= (state_next == GRANTED);
      grant_encoded <= encoded_next;
      mask          <= mask_next;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench: four arbiter configurations driven in lockstep and compared
// every cycle against a rotation-based reference model, plus directed scenarios.
module tb_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] request;
  logic [3:0] acknowledge;

  logic [3:0] gnt [4];
  logic       vld [4];
  logic [1:0] enc [4];

  int total = 0;
  int bad   = 0;

  // Per-instance configuration mirrored for the model: rr, lsb_high, block, block_ack.
  int rr_p  [4] = '{0, 1, 0, 1};
  int lsb_p [4] = '{0, 1, 0, 1};
  int blk_p [4] = '{0, 0, 1, 1};
  int ack_p [4] = '{1, 1, 0, 1};

  // Model state: granted port (-1 = none) and last port served.
  int cur  [4];
  int last [4];

  logic [3:0] seq2 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
               .ARB_LSB_HIGH_PRIORITY(0)) d0 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[0]), .grant_valid(vld[0]), .grant_encoded(enc[0]));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
               .ARB_LSB_HIGH_PRIORITY(1)) d1 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[1]), .grant_valid(vld[1]), .grant_encoded(enc[1]));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
               .ARB_LSB_HIGH_PRIORITY(0)) d2 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[2]), .grant_valid(vld[2]), .grant_encoded(enc[2]));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
               .ARB_LSB_HIGH_PRIORITY(1)) d3 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[3]), .grant_valid(vld[3]), .grant_encoded(enc[3]));

  // Next requester in rotation order after `lst`, else plain priority winner.
  function automatic int pick(input logic [3:0] r, input int rr, input int lsb, input int lst);
    if (r == 4'b0000) return -1;
    if (rr != 0) begin
      if (lsb != 0) begin
        for (int j = lst + 1; j < 4; j++) if (r[j]) return j;
      end else begin
        for (int j = lst - 1; j >= 0; j--) if (r[j]) return j;
      end
    end
    if (lsb != 0) begin
      for (int j = 0; j < 4; j++) if (r[j]) return j;
    end else begin
      for (int j = 3; j >= 0; j--) if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      cur[k]  = -1;
      last[k] = (lsb_p[k] != 0) ? -1 : 4;
    end
  endtask

  task automatic model_step();
    int w;
    bit rel;
    for (int k = 0; k < 4; k++) begin
      if (cur[k] < 0 || blk_p[k] == 0) rel = 1'b1;
      else if (ack_p[k] != 0)          rel = acknowledge[cur[k]];
      else                             rel = !request[cur[k]];
      if (rel) begin
        w = pick(request, rr_p[k], lsb_p[k], last[k]);
        cur[k] = w;
        if (w >= 0) last[k] = w;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d%0d_grant", k), 32'(gnt[k]), (cur[k] < 0) ? 32'd0 : (32'd1 << cur[k]));
      check($sformatf("d%0d_valid", k), 32'(vld[k]), (cur[k] < 0) ? 32'd0 : 32'd1);
      check($sformatf("d%0d_enc", k),   32'(enc[k]), (cur[k] < 0) ? 32'd0 : 32'(cur[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check_model();
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] a);
    request     = r;
    acknowledge = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 4'b0000);
    #1;
    model_reset();
    check_model();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive(4'b0000, 4'b0000);
    do_reset();

    // Fixed priority, MSB wins, re-arbitrated every cycle.
    drive(4'b0101, 4'b0000);
    repeat (3) begin
      tick();
      check("t1_grant", 32'(gnt[0]), 32'b0100);
      check("t1_enc",   32'(enc[0]), 32'd2);
      check("t1_valid", 32'(vld[0]), 32'd1);
    end

    // Round-robin rotation with all ports requesting.
    do_reset();
    drive(4'b1111, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_grant_%0d", i), 32'(gnt[1]), 32'(seq2[i]));
    end

    // Hold while the granted request stays high.
    do_reset();
    drive(4'b0010, 4'b0000);
    tick();
    check("t3_first", 32'(gnt[2]), 32'b0010);
    drive(4'b1010, 4'b0000);
    repeat (2) begin
      tick();
      check("t3_hold", 32'(gnt[2]), 32'b0010);
    end
    drive(4'b1000, 4'b0000);
    tick();
    check("t3_switch", 32'(gnt[2]), 32'b1000);

    // Hold until acknowledge on the granted port.
    do_reset();
    drive(4'b0100, 4'b0000);
    tick();
    check("t4_first", 32'(gnt[3]), 32'b0100);
    drive(4'b0000, 4'b0000);
    tick();
    check("t4_drop_hold", 32'(gnt[3]), 32'b0100);
    drive(4'b0000, 4'b0001);
    tick();
    check("t4_foreign_ack", 32'(gnt[3]), 32'b0100);
    drive(4'b1001, 4'b0100);
    tick();
    check("t4_ack_release", 32'(gnt[3]), 32'b1000);

    // Lone requester re-granted after its own acknowledge.
    do_reset();
    drive(4'b0100, 4'b0000);
    tick();
    check("t5_first", 32'(gnt[3]), 32'b0100);
    drive(4'b0100, 4'b0100);
    tick();
    check("t5_regrant", 32'(gnt[3]), 32'b0100);
    drive(4'b0100, 4'b0000);
    tick();

    // Asynchronous reset between edges, then rotation restarts from a full mask.
    do_reset();
    drive(4'b0110, 4'b0000);
    tick();
    check("t6_pre", 32'(gnt[0]), 32'b0100);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t6_async_grant_d%0d", k), 32'(gnt[k]), 32'd0);
      check($sformatf("t6_async_valid_d%0d", k), 32'(vld[k]), 32'd0);
      check($sformatf("t6_async_enc_d%0d", k),   32'(enc[k]), 32'd0);
    end
    model_reset();
    tick();
    rst = 1'b0;
    drive(4'b1111, 4'b0000);
    tick();
    check("t6_mask_d1", 32'(gnt[1]), 32'b0001);
    check("t6_mask_d3", 32'(gnt[3]), 32'b0001);

    // Random traffic against the model.
    repeat (400) begin
      drive(4'($urandom), 4'($urandom & $urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
